// File: rtl/int_freelist_pkg.sv
// Shared backend types for the integer physical-register free list.
// Widths are derived from IPHYREG_NUM, which must be a power of two.
package int_freelist_pkg;

  localparam int RENAME_WIDTH = 4;
  localparam int COMMIT_WIDTH = 4;
  localparam int IPHYREG_NUM  = 64;

  localparam int IPR_IDX_W = $clog2(IPHYREG_NUM);
  localparam int FL_PTR_W  = IPR_IDX_W + 1;

  typedef logic [IPR_IDX_W-1:0] iprIdx_t;
  // The extra MSB is the wrap bit; differences on the full width give counts.
  typedef logic [FL_PTR_W-1:0]  fl_ptr_t;

endpackage

// File: rtl/int_freelist_lane_prefix.sv
// Exclusive prefix popcount per lane plus the total count of set lanes.
// prefix_o[i] is the number of set bits in vld_i[i-1:0].
module lane_prefix_cnt #(
  parameter int N  = 4,
  parameter int CW = $clog2(N + 1)
) (
  input  logic [N-1:0]         vld_i,
  output logic [N-1:0][CW-1:0] prefix_o,
  output logic [CW-1:0]        total_o
);

  logic [CW-1:0] acc;

  // NOTE: the running sum relies on blocking assignments so that each lane
  // sees the count accumulated by the lanes before it in the same evaluation.
  always_comb begin
    acc      = '0;
    prefix_o = '0;
    for (int i = 0; i < N; i++) begin
      prefix_o[i] = acc;
      acc         = acc + CW'(vld_i[i]);
    end
    total_o = acc;
  end

endmodule

// File: rtl/int_freelist.sv
// Integer physical-register free list: circular buffer with speculative and
// architectural heads; squash rewinds the speculative head to the arch head.
module int_freelist
  import int_freelist_pkg::*;
#(
  parameter int WIDTH      = RENAME_WIDTH,
  parameter int COMMIT_WID = COMMIT_WIDTH,
  parameter int NUM_PHYREG = IPHYREG_NUM
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [WIDTH-1:0]          i_alloc_req,
  input  logic                      i_alloc_fire,
  output logic                      o_can_alloc,
  output iprIdx_t [WIDTH-1:0]       o_alloc_prd_idx,
  input  logic [COMMIT_WID-1:0]     i_commit_alloc_vld,
  input  logic [COMMIT_WID-1:0]     i_dealloc_vld,
  input  iprIdx_t [COMMIT_WID-1:0]  i_dealloc_prd_idx,
  input  logic                      i_squash_vld,
  output logic [FL_PTR_W-1:0]       o_free_num
);

  localparam int ACW = $clog2(WIDTH + 1);
  localparam int CCW = $clog2(COMMIT_WID + 1);

  iprIdx_t entry_q [NUM_PHYREG];
  fl_ptr_t spec_head_q, spec_head_d;
  fl_ptr_t arch_head_q, arch_head_d;
  fl_ptr_t tail_q, tail_d;
  fl_ptr_t occ_d;

  logic [WIDTH-1:0][ACW-1:0]      alloc_prefix;
  logic [ACW-1:0]                 alloc_total;
  logic [COMMIT_WID-1:0][CCW-1:0] dealloc_prefix;
  logic [CCW-1:0]                 dealloc_total;
  logic [COMMIT_WID-1:0][CCW-1:0] commit_prefix_unused;
  logic [CCW-1:0]                 commit_total;

  iprIdx_t [COMMIT_WID-1:0] wr_addr;
  logic                     alloc_en;

  lane_prefix_cnt #(.N(WIDTH), .CW(ACW)) u_alloc_cnt (
    .vld_i    (i_alloc_req),
    .prefix_o (alloc_prefix),
    .total_o  (alloc_total)
  );

  lane_prefix_cnt #(.N(COMMIT_WID), .CW(CCW)) u_dealloc_cnt (
    .vld_i    (i_dealloc_vld),
    .prefix_o (dealloc_prefix),
    .total_o  (dealloc_total)
  );

  lane_prefix_cnt #(.N(COMMIT_WID), .CW(CCW)) u_commit_cnt (
    .vld_i    (i_commit_alloc_vld),
    .prefix_o (commit_prefix_unused),
    .total_o  (commit_total)
  );

  // NOTE: every output of this block gets a default first, so no path can
  // leave a value held and infer a latch.
  always_comb begin
    fl_ptr_t rd_ptr;
    o_free_num      = tail_q - spec_head_q;
    o_can_alloc     = (o_free_num >= fl_ptr_t'(alloc_total));
    o_alloc_prd_idx = '0;
    for (int i = 0; i < WIDTH; i++) begin
      rd_ptr = spec_head_q + fl_ptr_t'(alloc_prefix[i]);
      if (i_alloc_req[i]) o_alloc_prd_idx[i] = entry_q[rd_ptr[IPR_IDX_W-1:0]];
    end
  end

  always_comb begin
    fl_ptr_t wp;
    wr_addr = '0;
    for (int i = 0; i < COMMIT_WID; i++) begin
      wp         = tail_q + fl_ptr_t'(dealloc_prefix[i]);
      wr_addr[i] = wp[IPR_IDX_W-1:0];
    end
  end

  assign alloc_en = i_alloc_fire & o_can_alloc & ~i_squash_vld;

  always_comb begin
    arch_head_d = arch_head_q + fl_ptr_t'(commit_total);
    tail_d      = tail_q + fl_ptr_t'(dealloc_total);
    spec_head_d = spec_head_q;
    if (i_squash_vld)  spec_head_d = arch_head_d;
    else if (alloc_en) spec_head_d = spec_head_q + fl_ptr_t'(alloc_total);
    occ_d = tail_d - arch_head_d;
  end

  // NOTE: the storage array is reset because allocation right after reset
  // must hand out 1,2,3,... ; entry[NUM_PHYREG-1] truncates to 0 and is
  // never read before a dealloc writes it.
  always_ff @(posedge clk) begin
    if (!rst) begin
      spec_head_q <= '0;
      arch_head_q <= '0;
      tail_q      <= fl_ptr_t'(NUM_PHYREG - 1);
      for (int k = 0; k < NUM_PHYREG; k++) entry_q[k] <= iprIdx_t'(k + 1);
    end else begin
      spec_head_q <= spec_head_d;
      arch_head_q <= arch_head_d;
      tail_q      <= tail_d;
      for (int i = 0; i < COMMIT_WID; i++) begin
        if (i_dealloc_vld[i]) entry_q[wr_addr[i]] <= i_dealloc_prd_idx[i];
      end
    end
  end

  // Protocol and ordering checks: arch_head <= spec_head <= tail, modulo.
  always @(posedge clk) begin
    if (rst) begin
      a_fire_without_room: assert (!(i_alloc_fire && !o_can_alloc));
      a_no_overflow:       assert (occ_d <= fl_ptr_t'(NUM_PHYREG - 1));
      a_spec_within_range: assert ((spec_head_d - arch_head_d) <= occ_d);
      for (int i = 0; i < COMMIT_WID; i++) begin
        a_no_x0_dealloc: assert (!(i_dealloc_vld[i] && i_dealloc_prd_idx[i] == '0));
      end
    end
  end

endmodule

// File: tb/tb_int_freelist.sv
// Directed bench for int_freelist: expectations are queued as stimulus is
// driven and popped against the DUT outputs sampled after the falling edge.
module tb_int_freelist;
  import int_freelist_pkg::*;

  logic                       clk = 1'b0;
  logic                       rst;
  logic [RENAME_WIDTH-1:0]    i_alloc_req;
  logic                       i_alloc_fire;
  logic                       o_can_alloc;
  iprIdx_t [RENAME_WIDTH-1:0] o_alloc_prd_idx;
  logic [COMMIT_WIDTH-1:0]    i_commit_alloc_vld;
  logic [COMMIT_WIDTH-1:0]    i_dealloc_vld;
  iprIdx_t [COMMIT_WIDTH-1:0] i_dealloc_prd_idx;
  logic                       i_squash_vld;
  logic [FL_PTR_W-1:0]        o_free_num;

  always #5 clk = ~clk;

  int_freelist dut (
    .clk                (clk),
    .rst                (rst),
    .i_alloc_req        (i_alloc_req),
    .i_alloc_fire       (i_alloc_fire),
    .o_can_alloc        (o_can_alloc),
    .o_alloc_prd_idx    (o_alloc_prd_idx),
    .i_commit_alloc_vld (i_commit_alloc_vld),
    .i_dealloc_vld      (i_dealloc_vld),
    .i_dealloc_prd_idx  (i_dealloc_prd_idx),
    .i_squash_vld       (i_squash_vld),
    .o_free_num         (o_free_num)
  );

  typedef enum int {K_LANE, K_FREE, K_CAN} kind_e;
  typedef struct {
    string tag;
    kind_e kind;
    int    lane;
    int    val;
  } exp_t;

  exp_t sb[$];
  int   checks = 0;
  int   errors = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, expv);
    end
  endtask

  task automatic drive(input logic rst_v, input logic [3:0] req, input logic fire,
                       input logic sq, input logic [3:0] cav, input logic [3:0] dvld,
                       input logic [23:0] didx);
    @(negedge clk);
    rst                = rst_v;
    i_alloc_req        = req;
    i_alloc_fire       = fire;
    i_squash_vld       = sq;
    i_commit_alloc_vld = cav;
    i_dealloc_vld      = dvld;
    i_dealloc_prd_idx  = didx;
  endtask

  task automatic exp_lanes(input string tag, input int v0, input int v1, input int v2, input int v3);
    sb.push_back('{tag: {tag, "_l0"}, kind: K_LANE, lane: 0, val: v0});
    sb.push_back('{tag: {tag, "_l1"}, kind: K_LANE, lane: 1, val: v1});
    sb.push_back('{tag: {tag, "_l2"}, kind: K_LANE, lane: 2, val: v2});
    sb.push_back('{tag: {tag, "_l3"}, kind: K_LANE, lane: 3, val: v3});
  endtask

  task automatic exp_free(input string tag, input int v);
    sb.push_back('{tag: {tag, "_free"}, kind: K_FREE, lane: 0, val: v});
  endtask

  task automatic exp_can(input string tag, input int v);
    sb.push_back('{tag: {tag, "_can"}, kind: K_CAN, lane: 0, val: v});
  endtask

  task automatic observe();
    exp_t e;
    #1;
    while (sb.size() > 0) begin
      e = sb.pop_front();
      case (e.kind)
        K_LANE:  check(e.tag, 32'(o_alloc_prd_idx[e.lane]), e.val);
        K_FREE:  check(e.tag, 32'(o_free_num), e.val);
        default: check(e.tag, 32'(o_can_alloc), e.val);
      endcase
    end
  endtask

  initial begin
    rst                = 1'b0;
    i_alloc_req        = '0;
    i_alloc_fire       = 1'b0;
    i_squash_vld       = 1'b0;
    i_commit_alloc_vld = '0;
    i_dealloc_vld      = '0;
    i_dealloc_prd_idx  = '0;
    repeat (2) @(posedge clk);

    // Reset state
    drive(1, 4'b0000, 0, 0, 4'b0000, 4'b0000, 24'd0);
    exp_free("rst", 63); exp_can("rst", 1); exp_lanes("rst", 0, 0, 0, 0);
    observe();

    // Test 1: first allocations after reset, sparse request compaction
    drive(1, 4'b1111, 1, 0, 4'b0000, 4'b0000, 24'd0);
    exp_lanes("t1_a", 1, 2, 3, 4); exp_free("t1_a", 63); exp_can("t1_a", 1);
    observe();
    drive(1, 4'b0101, 1, 0, 4'b0000, 4'b0000, 24'd0);
    exp_lanes("t1_b", 5, 0, 6, 0); exp_free("t1_b", 59);
    observe();

    // Test 2: drain to three free entries, then a 4-wide request cannot go
    for (int n = 0; n < 13; n++) begin
      drive(1, 4'b1111, 1, 0, 4'b0000, 4'b0000, 24'd0);
      exp_lanes($sformatf("t2_fill%0d", n), 6 + 4*n + 1, 6 + 4*n + 2, 6 + 4*n + 3, 6 + 4*n + 4);
      exp_free($sformatf("t2_fill%0d", n), 57 - 4*n);
      observe();
    end
    drive(1, 4'b0011, 1, 0, 4'b0000, 4'b0000, 24'd0);
    exp_lanes("t2_last", 59, 60, 0, 0); exp_free("t2_last", 5);
    observe();
    drive(1, 4'b1111, 0, 0, 4'b0000, 4'b0000, 24'd0);
    exp_can("t2_full", 0); exp_free("t2_full", 3);
    observe();
    drive(1, 4'b0111, 0, 0, 4'b0000, 4'b0000, 24'd0);
    exp_can("t2_exact", 1); exp_free("t2_exact", 3); exp_lanes("t2_exact", 61, 62, 63, 0);
    observe();

    // Test 6: reset with a pending fire and dealloc
    drive(0, 4'b1111, 1, 0, 4'b0000, 4'b0001, {6'd0, 6'd0, 6'd0, 6'd5});
    drive(1, 4'b0001, 0, 0, 4'b0000, 4'b0000, 24'd0);
    exp_free("t6_rst", 63); exp_lanes("t6_rst", 1, 0, 0, 0);
    observe();

    // Test 3: allocate 1..8, commit four, squash back to the arch head
    drive(1, 4'b1111, 1, 0, 4'b0000, 4'b0000, 24'd0);
    exp_lanes("t3_a", 1, 2, 3, 4);
    observe();
    drive(1, 4'b1111, 1, 0, 4'b0000, 4'b0000, 24'd0);
    exp_lanes("t3_b", 5, 6, 7, 8); exp_free("t3_b", 59);
    observe();
    drive(1, 4'b0000, 0, 1, 4'b1111, 4'b0000, 24'd0);
    exp_free("t3_sq", 55);
    observe();
    drive(1, 4'b0001, 0, 0, 4'b0000, 4'b0000, 24'd0);
    exp_free("t3_post", 59); exp_lanes("t3_post", 5, 0, 0, 0);
    observe();

    // Test 4: dealloc 9 and 12 across the wrap, then drain to them
    drive(1, 4'b0000, 0, 0, 4'b0000, 4'b0101, {6'd0, 6'd12, 6'd0, 6'd9});
    exp_free("t4_push", 59);
    observe();
    drive(1, 4'b0000, 0, 0, 4'b0000, 4'b0000, 24'd0);
    exp_free("t4_vis", 61);
    observe();
    for (int n = 0; n < 14; n++) begin
      drive(1, 4'b1111, 1, 0, 4'b0000, 4'b0000, 24'd0);
      exp_lanes($sformatf("t4_drain%0d", n), 4 + 4*n + 1, 4 + 4*n + 2, 4 + 4*n + 3, 4 + 4*n + 4);
      exp_free($sformatf("t4_drain%0d", n), 61 - 4*n);
      observe();
    end
    drive(1, 4'b1111, 1, 0, 4'b0000, 4'b0000, 24'd0);
    exp_lanes("t4_tail", 61, 62, 63, 9); exp_free("t4_tail", 5);
    observe();
    drive(1, 4'b0001, 1, 0, 4'b0000, 4'b0000, 24'd0);
    exp_lanes("t4_wrap", 12, 0, 0, 0); exp_free("t4_wrap", 1);
    observe();
    drive(1, 4'b0001, 0, 0, 4'b0000, 4'b0000, 24'd0);
    exp_can("t4_empty", 0); exp_free("t4_empty", 0);
    observe();

    // Refill four entries past the wrap while committing four
    drive(1, 4'b1111, 0, 0, 4'b1111, 4'b1111, {6'd23, 6'd22, 6'd21, 6'd20});
    exp_free("t5_pre", 0); exp_can("t5_pre", 0);
    observe();
    drive(1, 4'b1111, 0, 0, 4'b0000, 4'b0000, 24'd0);
    exp_free("t5_refill", 4); exp_can("t5_refill", 1); exp_lanes("t5_refill", 20, 21, 22, 23);
    observe();

    // Test 5: squash + fire + commit 2 + dealloc 1 in one cycle
    drive(1, 4'b1111, 1, 1, 4'b0011, 4'b0001, {6'd0, 6'd0, 6'd0, 6'd7});
    exp_free("t5_same", 4); exp_can("t5_same", 1);
    observe();
    drive(1, 4'b1111, 0, 0, 4'b0000, 4'b0000, 24'd0);
    exp_free("t5_post", 60); exp_lanes("t5_post", 11, 12, 13, 14);
    observe();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
